// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes and
// the select/ALU encodings driven onto the datapath.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    LIEX    = 4'd10,
    IWB     = 4'd11,
    JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the R-type funct field onto the
// single-cycle ALU control encoding.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls back to add so the writeback still has a value
        case (funct)
          6'b000000: alucontrol = ALU_SLL;
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style controller: Moore FSM sequencing fetch/decode/execute
// steps, plus a retired-instruction counter.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        iord,
  output logic        irwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic        zero_or_a,
  output logic        is_li,
  output logic        lessequal,
  output logic        pcen,
  output logic        illegal,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  state_t     state_q, state_n;
  logic [1:0] aluop;
  logic       pcwrite, branch, retire;
  logic       irwrite_s, memwrite_s, regwrite_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      instret <= '0;
    end else begin
      state_q <= state_n;
      if (retire) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_n    = FETCH;
    iord       = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    zero_or_a  = 1'b1;
    is_li      = 1'b0;
    lessequal  = 1'b0;
    illegal    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = SRCB_FOUR;
        pcwrite   = 1'b1;
        state_n   = DECODE;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW:   state_n = MEMADR;
          OP_RTYPE:       state_n = EXECUTE;
          OP_BEQ, OP_BLE: state_n = BRANCH;
          OP_ADDI:        state_n = ADDIEX;
          OP_LI:          state_n = LIEX;
          OP_J:           state_n = JUMP;
          default: begin
            illegal = 1'b1;
            state_n = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_n = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        retire     = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_n = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        retire     = 1'b1;
      end
      BRANCH: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = PC_ALUOUT;
        branch    = 1'b1;
        lessequal = (op == OP_BLE);
        retire    = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_n = IWB;
      end
      LIEX: begin
        alusrca   = 1'b1;
        zero_or_a = 1'b0;
        is_li     = 1'b1;
        alusrcb   = SRCB_IMM;
        state_n   = IWB;
      end
      IWB: begin
        regwrite_s = 1'b1;
        retire     = 1'b1;
      end
      JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  // Architectural write strobes are held off for the whole reset window
  assign pcen     = (pcwrite | (branch & zero)) & reset;
  assign irwrite  = irwrite_s & reset;
  assign memwrite = memwrite_s & reset;
  assign regwrite = regwrite_s & reset;
  assign state    = state_q;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an
// instruction-level model (per-opcode step lists and a retire counter).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero;
  logic        iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic        zero_or_a, is_li, lessequal, pcen, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .zero_or_a(zero_or_a), .is_li(is_li), .lessequal(lessequal), .pcen(pcen),
    .illegal(illegal), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state(state), .instret(instret)
  );

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_ADDIEX = 9, S_LIEX = 10, S_IWB = 11, S_JUMP = 12;
  localparam int B_ILLEGAL = 11, B_PCEN = 12, B_LESSEQUAL = 13, B_IS_LI = 14,
                 B_ZERO_OR_A = 15, B_REGDST = 18, B_REGWRITE = 19;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_state  = S_FETCH;
  logic [31:0] m_instret = '0;
  int          path[$];
  bit          m_retire;
  logic [22:0] snap [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h00:   return 3'b011;
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                     6'b011111, 6'b001000, 6'b010001, 6'b000010};
  endfunction

  // Outputs the specification lists for each step, given current inputs
  function automatic logic [22:0] expect_outs(input int st);
    logic io = 0, irw = 0, mw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, zoa = 1;
    logic li = 0, le = 0, ill = 0, pw = 0, br = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ac = 3'b010;
    case (st)
      S_FETCH:   begin irw = 1; sb = 2'b01; pw = 1; end
      S_DECODE:  begin sb = 2'b11; ill = !legal_op(op); end
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_EXECUTE: begin sa = 1; ac = funct_alu(funct); end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_BRANCH:  begin sa = 1; ac = 3'b110; ps = 2'b01; br = 1; le = (op == 6'b011111); end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_LIEX:    begin sa = 1; zoa = 0; li = 1; sb = 2'b10; end
      S_IWB:     rw = 1;
      S_JUMP:    begin ps = 2'b10; pw = 1; end
      default:   ;
    endcase
    return {io, irw & reset, mw & reset, rw & reset, rd, m2r, sa, zoa, li, le,
            (pw | (br & zero)) & reset, ill, sb, ps, ac, 4'(st)};
  endfunction

  task automatic plan(input logic [5:0] o);
    m_retire = 1;
    case (o)
      6'b100011:            path = {S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      6'b101011:            path = {S_DECODE, S_MEMADR, S_MEMWR};
      6'b000000:            path = {S_DECODE, S_EXECUTE, S_ALUWB};
      6'b000100, 6'b011111: path = {S_DECODE, S_BRANCH};
      6'b001000:            path = {S_DECODE, S_ADDIEX, S_IWB};
      6'b010001:            path = {S_DECODE, S_LIEX, S_IWB};
      6'b000010:            path = {S_DECODE, S_JUMP};
      default: begin
        path = {S_DECODE};
        m_retire = 0;
      end
    endcase
  endtask

  // Called just after a negedge with inputs set; compares, advances the model
  task automatic tick();
    logic [22:0] e, d;
    #1;
    e = expect_outs(m_state);
    d = {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, zero_or_a,
         is_li, lessequal, pcen, illegal, alusrcb, pcsrc, alucontrol, state};
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL outputs in step %0d: got %h expected %h", m_state, d, e);
    end
    chk("instret", instret, m_instret);
    snap[m_state] = d;
    if (!reset) begin
      m_state = S_FETCH;
      m_instret = '0;
      path.delete();
    end else if (m_state == S_FETCH) begin
      plan(op);
      m_state = path.pop_front();
    end else if (path.size() == 0) begin
      if (m_retire) m_instret++;
      m_state = S_FETCH;
    end else begin
      m_state = path.pop_front();
    end
    @(negedge clk);
  endtask

  // zmode: 0/1 fixed zero, 2 random; exp_cycles 0 skips the length check
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int exp_cycles, input bit rst_rand);
    int n = 0;
    op = o;
    funct = f;
    do begin
      zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      reset = (rst_rand && $urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      tick();
      n++;
    end while (m_state != S_FETCH && n < 20);
    if (exp_cycles > 0) chk("cycles per instruction", 32'(n), 32'(exp_cycles));
  endtask

  logic [5:0] ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b011111,
                           6'b001000, 6'b010001, 6'b000010, 6'b111111, 6'b000001,
                           6'b110000};
  logic [5:0] functs [7] = '{6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; op = '0; funct = '0; zero = 1'b0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post-reset state", 32'(state), 32'd0);
    chk("post-reset irwrite", 32'(irwrite), 32'd1);
    chk("post-reset pcen", 32'(pcen), 32'd1);
    chk("post-reset instret", instret, 32'd0);

    run_instr(6'b100011, 6'h00, 2, 5, 0);
    chk("lw regwrite memwb", 32'(snap[S_MEMWB][B_REGWRITE]), 32'd1);
    chk("lw regwrite memrd", 32'(snap[S_MEMRD][B_REGWRITE]), 32'd0);
    chk("lw instret", instret, 32'd1);

    run_instr(6'b011111, 6'h00, 1, 3, 0);
    chk("ble taken pcen", 32'(snap[S_BRANCH][B_PCEN]), 32'd1);
    chk("ble pcsrc", 32'(snap[S_BRANCH][8:7]), 32'd1);
    chk("ble lessequal", 32'(snap[S_BRANCH][B_LESSEQUAL]), 32'd1);
    run_instr(6'b011111, 6'h00, 0, 3, 0);
    chk("ble not-taken pcen", 32'(snap[S_BRANCH][B_PCEN]), 32'd0);
    chk("ble instret", instret, 32'd3);

    run_instr(6'b000000, 6'h00, 2, 4, 0);
    chk("sll alucontrol", 32'(snap[S_EXECUTE][6:4]), 32'd3);
    chk("aluwb regdst", 32'(snap[S_ALUWB][B_REGDST]), 32'd1);
    chk("aluwb regwrite", 32'(snap[S_ALUWB][B_REGWRITE]), 32'd1);

    run_instr(6'b010001, 6'h00, 2, 4, 0);
    chk("li zero_or_a", 32'(snap[S_LIEX][B_ZERO_OR_A]), 32'd0);
    chk("li is_li", 32'(snap[S_LIEX][B_IS_LI]), 32'd1);
    chk("li alusrcb", 32'(snap[S_LIEX][10:9]), 32'd2);
    chk("iwb regwrite", 32'(snap[S_IWB][B_REGWRITE]), 32'd1);

    run_instr(6'b111111, 6'h00, 2, 2, 0);
    chk("illegal flag", 32'(snap[S_DECODE][B_ILLEGAL]), 32'd1);
    chk("illegal instret", instret, 32'd5);

    op = 6'b101011; zero = 1'b0; reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("sw state before reset edge", 32'(state), 32'd5);
    chk("memwrite under reset", 32'(memwrite), 32'd0);
    tick();
    chk("state after reset", 32'(state), 32'd0);
    chk("instret after reset", instret, 32'd0);
    reset = 1'b1;

    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 32'hFFFF_FFFF;
    run_instr(6'b000010, 6'h00, 2, 3, 0);
    chk("instret wrap", instret, 32'd0);

    repeat (400) begin
      run_instr(ops[$urandom_range(0, 10)], functs[$urandom_range(0, 6)], 2, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
